// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: three bytes are held, and the fourth completes the word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  // The word is presented combinationally so the caller can register it on the 4th byte's edge.
  assign word      = {shreg, byte_in};
  assign word_done = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking, so both registers see the values they had before this edge.
      shreg <= {shreg[15:0], byte_in};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_t           state, state_nxt;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len, n_words, word_cnt;
  logic             xfer, shift_en, word_done, last_word;
  logic [31:0]      word;

  // A byte presented alongside start is dropped: start wins over everything.
  assign xfer      = s_valid && s_ready && !start;
  assign len       = {len_hi, s_data};
  assign shift_en  = xfer && (state == S_DATA);
  assign last_word = word_done && (word_cnt == n_words - LEN_W'(1));

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .shift_en  (shift_en),
    .byte_in   (s_data),
    .word      (word),
    .word_done (word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHK;
  logic [7:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum <= '0;
    else if (start)    csum <= '0;
    else if (shift_en) csum <= csum ^ s_data;
  end
`else
  localparam state_t END_STATE = S_DONE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so a path that assigns nothing holds state instead of inferring a latch.
    state_nxt = state;
    if (start) begin
      state_nxt = S_LEN_HI;
    end else if (xfer) begin
      case (state)
        S_LEN_HI: state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if (32'(len) > DEPTH)  state_nxt = S_ERR;
          else if (len == '0)    state_nxt = END_STATE;
          else                   state_nxt = S_DATA;
        end
        S_DATA:   if (last_word) state_nxt = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK:    state_nxt = (s_data == csum) ? S_DONE : S_ERR;
`endif
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    s_ready  = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: s_ready = 1'b1;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // The word counter doubles as the write address; it never exceeds DEPTH-1 while writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        len_hi   <= '0;
        n_words  <= '0;
        word_cnt <= '0;
        wr_addr  <= '0;
        wr_data  <= '0;
      end else begin
        if (xfer && state == S_LEN_HI) len_hi  <= s_data;
        if (xfer && state == S_LEN_LO) n_words <= len;
        if (word_done) begin
          wr_en    <= 1'b1;
          wr_addr  <= ADDR_W'(word_cnt);
          wr_data  <= word;
          word_cnt <= word_cnt + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a byte-list reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready, wr_en, cpu_hold, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  logic              last_wr_en, last_done, last_hold;
  bit                load_ok;
  int                load_cycles;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: how many bytes the loader consumes, the words it must write, and the outcome.
  function automatic void model(input byte_q_t img, output int consumed, output bit exp_err,
                                output word_q_t words);
    int n;
    logic [7:0] x;
    words   = {};
    x       = 8'h00;
    exp_err = 1'b0;
    n       = int'({img[0], img[1]});
    if (n > DEPTH) begin
      consumed = 2;
      exp_err  = 1'b1;
      return;
    end
    for (int j = 0; j < n; j++)
      words.push_back({img[2+4*j], img[3+4*j], img[4+4*j], img[5+4*j]});
    consumed = 2 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 2; k < consumed; k++) x = x ^ img[k];
    exp_err  = (img[consumed] !== x);
    consumed = consumed + 1;
`endif
  endfunction

  function automatic void add_csum(input byte_q_t img, input bit corrupt, output byte_q_t res);
    logic [7:0] x;
    x   = 8'h00;
    res = img;
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 2; k < img.size(); k++) x = x ^ img[k];
    res.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
  endfunction

  function automatic int write_diffs(input word_q_t exp);
    int d = 0;
    if (cap_data.size() != exp.size()) d++;
    for (int i = 0; i < cap_data.size() && i < exp.size(); i++) begin
      if (cap_data[i] !== exp[i]) d++;
      if (cap_addr[i] !== ADDR_W'(i)) d++;
    end
    return d;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    if (gap > 0) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start (with junk valid alongside, which must be ignored) then streams n_send bytes.
  task automatic run_load(input byte_q_t img, input int n_send, input int gap_min, input int gap_max);
    bit ok;
    int c0;
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc;
    cap_addr.delete();
    cap_data.delete();
    load_ok = 1'b1;
    for (int i = 0; i < n_send && load_ok; i++) begin
      send_byte(img[i], $urandom_range(gap_max, gap_min), ok);
      if (!ok) load_ok = 1'b0;
    end
    load_cycles = cyc - c0;
    last_wr_en  = wr_en;
    last_done   = done;
    last_hold   = cpu_hold;
    s_valid     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({s_ready, wr_en, cpu_hold, done, err} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 00100", {s_ready, wr_en, cpu_hold, done, err});
    end
    tests_run++;
    if (wr_addr !== '0 || wr_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr %h data %h required 0/0", wr_addr, wr_data);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({s_ready, cpu_hold, done, err} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL idle_flags: got %b required 0100", {s_ready, cpu_hold, done, err});
    end
  endtask

  task automatic test_basic(input int gap);
    byte_q_t img;
    word_q_t exp;
    int cons, d;
    bit e;
    img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    add_csum(img, 1'b0, img);
    model(img, cons, e, exp);
    run_load(img, cons, gap, gap);
    tests_run++;
    if (!load_ok) begin
      tests_failed++;
      $display("FAIL basic_handshake gap=%0d: got stall required all %0d bytes accepted", gap, cons);
    end
    d = write_diffs(exp);
    tests_run++;
    if (d != 0) begin
      tests_failed++;
      $display("FAIL basic_writes gap=%0d: got %0d words (%0d differ) required %0d", gap, cap_data.size(), d, exp.size());
    end
    tests_run++;
    if (cap_data.size() != 2 || cap_data[0] !== 32'h20080005 || cap_data[1] !== 32'h8C090004) begin
      tests_failed++;
      $display("FAIL basic_words gap=%0d: got %0d words required 20080005,8c090004", gap, cap_data.size());
    end
    tests_run++;
    if ({done, err, cpu_hold, s_ready} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL basic_flags gap=%0d: got %b required 1000", gap, {done, err, cpu_hold, s_ready});
    end
    if (gap == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      tests_run++;
      if ({last_done, last_hold} !== 2'b10) begin
        tests_failed++;
        $display("FAIL basic_final_edge: got done/hold %b required 10", {last_done, last_hold});
      end
`else
      tests_run++;
      if ({last_wr_en, last_done, last_hold} !== 3'b110) begin
        tests_failed++;
        $display("FAIL basic_final_edge: got wr_en/done/hold %b required 110", {last_wr_en, last_done, last_hold});
      end
`endif
      tests_run++;
      if (load_cycles != cons) begin
        tests_failed++;
        $display("FAIL basic_latency: got %0d cycles required %0d", load_cycles, cons);
      end
    end
  endtask

  task automatic test_oversize();
    byte_q_t img;
    word_q_t exp;
    int cons, d;
    bit e;
    img = {8'h01, 8'h01, 8'hAA, 8'hBB};
    model(img, cons, e, exp);
    run_load(img, cons, 0, 0);
    tests_run++;
    if ({done, err, cpu_hold, s_ready} !== 4'b0110 || cap_data.size() != 0) begin
      tests_failed++;
      $display("FAIL oversize: got flags %b writes %0d required 0110 and 0 writes", {done, err, cpu_hold, s_ready}, cap_data.size());
    end
    // Exactly DEPTH words is the largest legal image.
    img = {8'(DEPTH >> 8), 8'(DEPTH)};
    for (int i = 0; i < 4 * DEPTH; i++) img.push_back(8'($urandom));
    add_csum(img, 1'b0, img);
    model(img, cons, e, exp);
    run_load(img, cons, 0, 0);
    d = write_diffs(exp);
    tests_run++;
    if (d != 0 || !load_ok || {done, err, cpu_hold} !== 3'b100) begin
      tests_failed++;
      $display("FAIL full_depth: got %0d words (%0d differ) flags %b required %0d words flags 100", cap_data.size(), d, {done, err, cpu_hold}, exp.size());
    end
  endtask

  task automatic test_zero();
    byte_q_t img;
    word_q_t exp;
    int cons;
    bit e;
    img = {8'h00, 8'h00};
    add_csum(img, 1'b0, img);
    model(img, cons, e, exp);
    run_load(img, cons, 0, 0);
    tests_run++;
    if ({done, err, cpu_hold} !== 3'b100 || cap_data.size() != 0 || !load_ok) begin
      tests_failed++;
      $display("FAIL zero_len: got flags %b writes %0d required 100 and 0 writes", {done, err, cpu_hold}, cap_data.size());
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    img = {8'h00, 8'h00, 8'h01};
    run_load(img, 3, 0, 0);
    tests_run++;
    if ({done, err, cpu_hold} !== 3'b011 || cap_data.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_len_badsum: got flags %b writes %0d required 011 and 0 writes", {done, err, cpu_hold}, cap_data.size());
    end
`endif
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t img;
    img = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load(img, 7, 0, 0);
    tests_run++;
    if ({done, err} !== 2'b10 || cap_data.size() != 1 || cap_data[0] !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL csum_good: got done/err %b writes %0d required 10 and 12345678@0", {done, err}, cap_data.size());
    end
    img[6] = 8'h09;
    run_load(img, 7, 0, 0);
    tests_run++;
    if ({done, err, cpu_hold} !== 3'b011 || cap_data.size() != 1 || cap_data[0] !== 32'h12345678 || cap_addr[0] !== '0) begin
      tests_failed++;
      $display("FAIL csum_bad: got flags %b writes %0d required 011 and 12345678@0", {done, err, cpu_hold}, cap_data.size());
    end
  endtask
`endif

  task automatic test_random();
    byte_q_t img;
    word_q_t exp;
    int cons, n, d;
    bit e, over;
    for (int it = 0; it < 12; it++) begin
      over = ($urandom_range(5, 0) == 0);
      n    = over ? DEPTH + 1 + $urandom_range(40, 0) : $urandom_range(6, 0);
      img  = {8'(n >> 8), 8'(n)};
      if (!over) for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      add_csum(img, $urandom_range(3, 0) == 0, img);
      model(img, cons, e, exp);
      run_load(img, cons, 0, 2);
      d = write_diffs(exp);
      tests_run++;
      if (d != 0 || !load_ok) begin
        tests_failed++;
        $display("FAIL random[%0d] writes n=%0d: got %0d words (%0d differ, ok=%0b) required %0d", it, n, cap_data.size(), d, load_ok, exp.size());
      end
      tests_run++;
      if ({done, err, cpu_hold, s_ready} !== (e ? 4'b0110 : 4'b1000)) begin
        tests_failed++;
        $display("FAIL random[%0d] flags n=%0d: got %b required %b", it, n, {done, err, cpu_hold, s_ready}, e ? 4'b0110 : 4'b1000);
      end
    end
  endtask

  task automatic test_abort();
    byte_q_t img;
    word_q_t exp;
    int cons, d;
    bit e;
    img = {8'h00, 8'h03};
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    add_csum(img, 1'b0, img);
    run_load(img, 5, 0, 0);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({s_ready, wr_en, cpu_hold, done, err} !== 5'b00100 || wr_addr !== '0 || wr_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL abort_rst: got flags %b addr %h data %h required 00100/0/0", {s_ready, wr_en, cpu_hold, done, err}, wr_addr, wr_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    // One word written and two bytes into the next, then restart with a fresh image.
    run_load(img, 8, 0, 0);
    tests_run++;
    if (cap_data.size() != 1) begin
      tests_failed++;
      $display("FAIL abort_partial: got %0d words required 1", cap_data.size());
    end
    img = {8'h00, 8'h02};
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    add_csum(img, 1'b0, img);
    model(img, cons, e, exp);
    run_load(img, cons, 0, 1);
    d = write_diffs(exp);
    tests_run++;
    if (d != 0 || {done, err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL abort_restart: got %0d words (%0d differ) done/err %b required %0d words 10", cap_data.size(), d, {done, err}, exp.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_oversize();
    test_zero();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the five-stage pipelined MIPS core. It receives a program image as a byte stream over a valid/ready interface, packs the bytes big-endian into 32-bit words, and writes them to consecutive instruction-memory word addresses starting at 0. While loading, it holds the core's PC so that fetch, the read side of instruction memory, starts only on a complete image.

## Interface
- ADDR_W, default 8: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins or restarts a load.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  word to write.
- cpu_hold  out  1  held high to freeze the PC and fetch.
- done  out  1  image loaded successfully (level).
- err  out  1  load rejected (level).

## Operation
- Stream format: LEN_HI, LEN_LO (N = 16-bit word count), then 4N data bytes, with the first byte in each group at [31:24].
- Handshake: a byte transfers on a clock edge where s_valid and s_ready are both high. The sender may hold s_valid with unchanged data indefinitely.
- States and transitions:
  - IDLE → LEN_HI on start.
  - LEN_HI → LEN_LO on transfer.
  - LEN_LO on transfer:
    - N > DEPTH → ERR.
    - N = 0 → END.
    - otherwise → DATA.
  - DATA: counts bytes. The 4th byte of each word issues a write. After the byte 4N transfers → END.
  - END is the pseudo-state for the trailing transition: → CHK if the checksum is enabled, else → DONE.
  - DONE and ERR are held until start or rst.
- s_ready = 1 in LEN_HI, LEN_LO, DATA and CHK; 0 elsewhere.
- cpu_hold = 1 in every state except DONE.
- done = 1 only in DONE.
- err = 1 only in ERR.
- start in any state clears all counters and the checksum, and sets err=0 and done=0. The next state is LEN_HI. A transfer occurring in the same cycle is ignored.
- wr_addr starts at 0 and increments by 1 per word. It cannot wrap, because N ≤ DEPTH.
- The internal word counter is 16 bits wide. The byte-in-word counter is 2 bits and wraps 3→0.

## Timing
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0. State after reset is IDLE.
- wr_en, wr_addr and wr_data are registered. They are valid for exactly the one cycle after the edge that transfers byte 4k+3.
- DONE is entered on the edge that transfers the final byte. With back-to-back valid, a full load takes 2 + 4N (+1 for the checksum) transfer cycles after start.
- The final wr_en pulse coincides with the first cycle of done=1 and cpu_hold=0. The memory write completes on that edge, before fetch of address 0 reads it.
- rst mid-load: the block returns to IDLE immediately. Memory words already written remain.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the data bytes, the block enters CHK and accepts one more byte.
  - That byte is compared to the XOR of all 4N data bytes; the length bytes are excluded.
  - Equal → DONE. Unequal → ERR.
  - Data words are already written in either case.
  - For N=0 the expected checksum is 0x00.
- Undefined: the CHK state and the XOR register are absent. The last data byte goes directly to DONE.

## Structure
- imem_loader_pkg: state enumeration (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR), BYTES_PER_WORD=4, LEN_BYTES=2.
- Sub-module byte_packer: a shift-in register plus a 2-bit byte counter. It emits the assembled 32-bit word and a word_done pulse.
- The top level holds the FSM, word counter, address, checksum and output registers.

## Test plan
- Basic load: N=2, bytes 0x00,0x02,0x20,0x08,0x00,0x05,0x8C,0x09,0x00,0x04 with continuous valid → writes 0x20080005 to addr 0 and 0x8C090004 to addr 1, then done=1, cpu_hold=0.
- Backpressure and gaps: same image with s_valid toggled every other cycle → identical writes, no duplicated or skipped bytes.
- Oversize image: ADDR_W=8, N=0x0101 → err=1 after LEN_LO, no wr_en, cpu_hold stays 1. A following start plus a valid image → done=1.
- N=0: bytes 0x00,0x00 → done=1 with no writes. With the checksum enabled, a following 0x00 is required; 0x01 → err=1.
- Checksum (macro defined): N=1, data 0x12,0x34,0x56,0x78, checksum 0x08 → done=1. Checksum 0x09 → err=1, with the word still written at addr 0.
- Abort: rst asserted after 3 data bytes → all outputs return to reset values immediately. A start pulse mid-DATA restarts, and addresses begin again at 0.
